// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state encoding and defaults for the data-memory port arbiter
package dmem_port_arbiter_pkg;
  typedef enum logic [1:0] {NORMAL, FORCE_ST, DRAIN} dmem_arb_state_e;
  localparam int DMEM_STARVE_LIMIT = 4;
endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: schedules the single-ported data SRAM between execute loads and store-buffer drains
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE_P    = 16,
  parameter int STARVE_LIMIT_P = DMEM_STARVE_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   exe_ld_v_i,
  input  logic [WORD_SIZE_P-1:0] exe_ld_addr_i,
  output logic                   ld_grant_o,
  output logic                   ld_data_v_o,
  output logic [WORD_SIZE_P-1:0] ld_data_o,
  input  logic                   sb_st_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_st_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_st_data_i,
  output logic                   sb_st_yumi_o,
  input  logic                   flush_i,
  input  logic                   drain_req_i,
  output logic                   drain_done_o,
  output logic                   mem_v_o,
  output logic                   mem_w_o,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_wdata_o,
  input  logic [WORD_SIZE_P-1:0] mem_rdata_i
);
  localparam int CW = $clog2(STARVE_LIMIT_P + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT_P);
  dmem_arb_state_e state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic ld_pend_q, ld_pend_d;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      ld_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ld_pend_q    <= ld_pend_d;
    end
  end
  // Starvation is judged on the updated count so the store is forced on the very next cycle.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = '0;
    case (state_q)
      NORMAL: begin
        starve_cnt_d = sb_st_yumi_o ? '0 :
                       (exe_ld_v_i && sb_st_v_i && starve_cnt_q != LIMIT) ? starve_cnt_q + CW'(1) :
                       starve_cnt_q;
        state_d = drain_req_i ? DRAIN : (starve_cnt_d == LIMIT) ? FORCE_ST : NORMAL;
      end
      FORCE_ST: state_d = drain_req_i ? DRAIN : NORMAL;
      DRAIN:    state_d = sb_st_v_i ? DRAIN : NORMAL;
      default:  state_d = NORMAL;
    endcase
    ld_pend_d = ld_grant_o & ~flush_i;
  end
  always_comb begin
    ld_grant_o   = ~reset_i & exe_ld_v_i &
                   ((state_q == NORMAL) | ((state_q == FORCE_ST) & ~sb_st_v_i));
    sb_st_yumi_o = ~reset_i & sb_st_v_i & ((state_q != NORMAL) | ~exe_ld_v_i);
    mem_v_o      = ld_grant_o | sb_st_yumi_o;
    mem_w_o      = sb_st_yumi_o;
    mem_addr_o   = sb_st_yumi_o ? sb_st_addr_i : ld_grant_o ? exe_ld_addr_i : '0;
    mem_wdata_o  = sb_st_yumi_o ? sb_st_data_i : '0;
    drain_done_o = ~reset_i & (state_q == DRAIN) & ~sb_st_v_i;
    ld_data_v_o  = ~reset_i & ld_pend_q & ~flush_i;
    ld_data_o    = ld_data_v_o ? mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus checked against a behavioural arbitration model every cycle
module tb_dmem_port_arbiter;
  localparam int W = 16;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset_i, exe_ld_v_i, flush_i, drain_req_i, sb_st_v_i;
  logic [W-1:0] exe_ld_addr_i, sb_st_addr_i, sb_st_data_i, mem_rdata_i;
  logic ld_grant_o, ld_data_v_o, sb_st_yumi_o, drain_done_o, mem_v_o, mem_w_o;
  logic [W-1:0] ld_data_o, mem_addr_o, mem_wdata_o;
  int errs = 0;
  int checks = 0;
  logic [W-1:0] sram [256];
  logic [W-1:0] mmem [256];
  bit m_drain, m_force, m_pend;
  int m_den;
  logic [W-1:0] m_pdata;

  dmem_port_arbiter #(.WORD_SIZE_P(W), .STARVE_LIMIT_P(LIM)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .exe_ld_v_i(exe_ld_v_i), .exe_ld_addr_i(exe_ld_addr_i),
    .ld_grant_o(ld_grant_o), .ld_data_v_o(ld_data_v_o), .ld_data_o(ld_data_o),
    .sb_st_v_i(sb_st_v_i), .sb_st_addr_i(sb_st_addr_i), .sb_st_data_i(sb_st_data_i),
    .sb_st_yumi_o(sb_st_yumi_o), .flush_i(flush_i), .drain_req_i(drain_req_i),
    .drain_done_o(drain_done_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o[7:0]] <= mem_wdata_o;
      else mem_rdata_i <= sram[mem_addr_o[7:0]];
    end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit e_ld();
    return !reset_i && !m_drain && exe_ld_v_i && !(m_force && sb_st_v_i);
  endfunction
  function automatic bit e_st();
    return !reset_i && sb_st_v_i && (m_drain || m_force || !exe_ld_v_i);
  endfunction

  // Model: loads win unless draining or a forced store is pending; denials count contended cycles.
  always @(posedge clk) begin
    bit gl, gs;
    gl = e_ld();
    gs = e_st();
    if (reset_i) begin
      m_drain = 0; m_force = 0; m_den = 0; m_pend = 0;
    end else begin
      m_pend = gl && !flush_i;
      if (gl) m_pdata = mmem[exe_ld_addr_i[7:0]];
      if (gs) mmem[sb_st_addr_i[7:0]] = sb_st_data_i;
      if (gs) m_den = 0;
      else if (!m_drain && !m_force && exe_ld_v_i && sb_st_v_i && m_den < LIM) m_den++;
      if (m_drain) begin
        if (!sb_st_v_i) begin m_drain = 0; m_den = 0; end
      end else if (drain_req_i) begin
        m_drain = 1; m_force = 0;
      end else if (m_force) begin
        m_force = 0; m_den = 0;
      end else if (m_den == LIM) m_force = 1;
    end
  end

  always @(negedge clk) begin
    bit gl, gs, dv;
    gl = e_ld();
    gs = e_st();
    dv = !reset_i && m_pend && !flush_i;
    chk("m_ld_grant", W'(ld_grant_o), W'(gl));
    chk("m_yumi", W'(sb_st_yumi_o), W'(gs));
    chk("m_mem_v", W'(mem_v_o), W'(gl | gs));
    chk("m_mem_w", W'(mem_w_o), W'(gs));
    chk("m_mem_addr", mem_addr_o, gs ? sb_st_addr_i : gl ? exe_ld_addr_i : '0);
    chk("m_mem_wdata", mem_wdata_o, gs ? sb_st_data_i : '0);
    chk("m_drain_done", W'(drain_done_o), W'(!reset_i && m_drain && !sb_st_v_i));
    chk("m_ld_data_v", W'(ld_data_v_o), W'(dv));
    chk("m_ld_data", ld_data_o, dv ? m_pdata : '0);
  end

  task automatic cyc(input bit lv, input logic [W-1:0] la, input bit sv,
                     input logic [W-1:0] sa, input logic [W-1:0] sd,
                     input bit fl, input bit dr, input bit rs);
    @(posedge clk);
    #1;
    exe_ld_v_i = lv; exe_ld_addr_i = la; sb_st_v_i = sv; sb_st_addr_i = sa;
    sb_st_data_i = sd; flush_i = fl; drain_req_i = dr; reset_i = rs;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = W'(i * 257) ^ 16'hA5A5;
      mmem[i] = sram[i];
    end
    sram[16] = 16'hBEEF;
    mmem[16] = 16'hBEEF;
    mem_rdata_i = '0;
    m_drain = 0; m_force = 0; m_pend = 0; m_den = 0; m_pdata = '0;
    reset_i = 1; exe_ld_v_i = 0; exe_ld_addr_i = '0; sb_st_v_i = 0;
    sb_st_addr_i = '0; sb_st_data_i = '0; flush_i = 0; drain_req_i = 0;
    cyc(1, 16'h10, 1, 16'h11, 16'h1, 0, 0, 1);
    chk("rst_grant", W'(ld_grant_o | sb_st_yumi_o), '0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ld_data_v", W'(ld_data_v_o), '0);
    chk("rst_mem_v", W'(mem_v_o), '0);
    chk("rst_ld_data", ld_data_o, '0);
    cyc(1, 16'h0010, 0, 0, 0, 0, 0, 0);
    chk("load_grant", W'(ld_grant_o), 1);
    chk("load_mem_addr", mem_addr_o, 16'h0010);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("load_data_v", W'(ld_data_v_o), 1);
    chk("load_data", ld_data_o, 16'hBEEF);
    cyc(0, 0, 1, 16'h0020, 16'h1234, 0, 0, 0);
    chk("store_yumi", W'(sb_st_yumi_o), 1);
    chk("store_mem_w", W'(mem_w_o), 1);
    cyc(1, 16'h0020, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("store_readback", ld_data_o, 16'h1234);
    for (int i = 0; i < 6; i++) begin
      cyc(1, W'(16'h30 + i), 1, 16'h40, 16'h5555, 0, 0, 0);
      chk($sformatf("contend_ld%0d", i), W'(ld_grant_o), W'(i != 4));
      chk($sformatf("contend_st%0d", i), W'(sb_st_yumi_o), W'(i == 4));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 16'h31, 1, 16'h60, 16'h0A0A, 0, 1, 0);
    chk("drain_req_ld", W'(ld_grant_o), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h31, 1, W'(16'h60 + i), W'(16'h0A0A + i), 0, 0, 0);
      chk($sformatf("drain_yumi%0d", i), W'(sb_st_yumi_o), 1);
      chk($sformatf("drain_noload%0d", i), W'(ld_grant_o), 0);
      chk($sformatf("drain_nodone%0d", i), W'(drain_done_o), 0);
    end
    cyc(1, 16'h31, 0, 0, 0, 0, 0, 0);
    chk("drain_done", W'(drain_done_o), 1);
    chk("drain_done_noload", W'(ld_grant_o), 0);
    cyc(1, 16'h62, 0, 0, 0, 0, 0, 0);
    chk("post_drain_ld", W'(ld_grant_o), 1);
    chk("post_drain_done", W'(drain_done_o), 0);
    cyc(1, 16'h10, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("flush_t1", W'(ld_data_v_o), 0);
    cyc(1, 16'h10, 0, 0, 0, 1, 0, 0);
    chk("flush_t_grant", W'(ld_grant_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_t0", W'(ld_data_v_o), 0);
    cyc(1, 16'h70, 1, 16'h80, 16'h0101, 0, 1, 0);
    cyc(1, 16'h70, 1, 16'h80, 16'h0101, 0, 0, 0);
    chk("rdrain_yumi", W'(sb_st_yumi_o), 1);
    cyc(1, 16'h70, 1, 16'h81, 16'h0202, 0, 0, 1);
    chk("rdrain_rst_done", W'(drain_done_o), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h70, 1, 16'h81, 16'h0202, 0, 0, 0);
      chk($sformatf("rdrain_ld%0d", i), W'(ld_grant_o), W'(i != 4));
      chk($sformatf("rdrain_st%0d", i), W'(sb_st_yumi_o), W'(i == 4));
      chk($sformatf("rdrain_done%0d", i), W'(drain_done_o), 0);
    end
    for (int i = 0; i < 4; i++) cyc(1, 16'h71, 1, 16'h82, 16'h0303, 0, 0, 0);
    cyc(1, 16'h72, 0, 0, 0, 0, 0, 0);
    chk("force_nost_ld", W'(ld_grant_o), 1);
    chk("force_nost_yumi", W'(sb_st_yumi_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("force_nost_data", ld_data_o, 16'h72 * 16'd257 ^ 16'hA5A5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
